// File: rtl/uart_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer_ctrl
// Description : UART receiver end-of-frame sequencer with a circular word FIFO,
//               receiver back-pressure, and saturating overrun/framing counters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer_ctrl #(
    parameter int word_size = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 Sample_clk,
    input  logic                 rst_b,
    input  logic [word_size-1:0] RCV_datareg,
    input  logic                 read_not_ready_out,
    input  logic                 Error1,
    input  logic                 Error2,
    output logic                 read_not_ready_in,
    input  logic                 rd_req,
    output logic [word_size-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_W:0]      count,
    output logic [CNT_W-1:0]     overrun_cnt,
    output logic [CNT_W-1:0]     framing_cnt,
    output logic                 err_sticky,
    input  logic                 clr_err
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]  C_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic [word_size-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]       overrun_cnt_q, overrun_cnt_d;
    logic [CNT_W-1:0]       framing_cnt_q, framing_cnt_d;
    logic                   err_sticky_q, err_sticky_d;

    logic [word_size-1:0]   mem [DEPTH];

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_drop;
    logic                   w_ovr_evt;
    logic                   w_frm_evt;

    // A new error in the same cycle as clr_err restarts its counter at 1.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] res;
        res = cur;
        if (clr) begin
            res = inc ? CNT_W'(1) : '0;
        end else if (inc && (cur != C_CNT_MAX)) begin
            res = cur + CNT_W'(1);
        end
        return res;
    endfunction

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_DEPTH);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        w_wr_en       = 1'b0;
        w_drop        = 1'b0;
        w_pop         = rd_req && !w_empty;

        unique case (state_q)
            ST_IDLE: begin
                if (read_not_ready_out && !Error1 && !Error2) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The receiver's data register settles on the edge ending the pulse.
                state_d = ST_IDLE;
                if (w_full) begin
                    w_drop = 1'b1;
                end else begin
                    w_wr_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        count_d = count_q + (ADDR_W + 1)'(w_wr_en) - (ADDR_W + 1)'(w_pop);
    end

    always_comb begin
        w_ovr_evt     = Error1 || w_drop;
        w_frm_evt     = Error2;
        overrun_cnt_d = cnt_next(overrun_cnt_q, w_ovr_evt, clr_err);
        framing_cnt_d = cnt_next(framing_cnt_q, w_frm_evt, clr_err);
        err_sticky_d  = err_sticky_q;
        if (w_ovr_evt || w_frm_evt) begin
            err_sticky_d = 1'b1;
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge Sample_clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            overrun_cnt_q <= '0;
            framing_cnt_q <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            overrun_cnt_q <= overrun_cnt_d;
            framing_cnt_q <= framing_cnt_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge Sample_clk) begin
        if (w_wr_en) begin
            mem[wr_ptr_q] <= RCV_datareg;
        end
    end

    assign read_not_ready_in = w_full;
    assign rd_data           = rd_data_q;
    assign rd_valid          = rd_valid_q;
    assign empty             = w_empty;
    assign full              = w_full;
    assign count             = count_q;
    assign overrun_cnt       = overrun_cnt_q;
    assign framing_cnt       = framing_cnt_q;
    assign err_sticky        = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_buffer_ctrl
// Description : Scoreboard bench for uart_rx_buffer_ctrl against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer_ctrl;

    localparam int WS    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_b;
    logic [WS-1:0] RCV_datareg;
    logic          read_not_ready_out;
    logic          Error1;
    logic          Error2;
    logic          read_not_ready_in;
    logic          rd_req;
    logic [WS-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic [CW-1:0] overrun_cnt;
    logic [CW-1:0] framing_cnt;
    logic          err_sticky;
    logic          clr_err;

    uart_rx_buffer_ctrl #(
        .word_size(WS), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .Sample_clk        (clk),
        .rst_b             (rst_b),
        .RCV_datareg       (RCV_datareg),
        .read_not_ready_out(read_not_ready_out),
        .Error1            (Error1),
        .Error2            (Error2),
        .read_not_ready_in (read_not_ready_in),
        .rd_req            (rd_req),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .empty             (empty),
        .full              (full),
        .count             (count),
        .overrun_cnt       (overrun_cnt),
        .framing_cnt       (framing_cnt),
        .err_sticky        (err_sticky),
        .clr_err           (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of words, the errors are plain integers.
    logic [WS-1:0] mq[$];
    logic [WS-1:0] exp_q[$];
    bit            m_pend;
    bit            m_valid;
    int            m_ovr;
    int            m_frm;
    bit            m_err;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mq.delete();
            exp_q.delete();
            m_pend  = 0;
            m_valid = 0;
            m_ovr   = 0;
            m_frm   = 0;
            m_err   = 0;
        end else begin
            int  sz;
            bit  ovr_evt;
            sz      = mq.size();
            ovr_evt = Error1;
            m_valid = 0;
            if (rd_req && sz > 0) begin
                exp_q.push_back(mq.pop_front());
                m_valid = 1;
            end
            if (m_pend) begin
                if (sz < DEPTH) mq.push_back(RCV_datareg);
                else            ovr_evt = 1;
            end
            m_pend = read_not_ready_out && !Error1 && !Error2;
            if (clr_err) begin
                m_ovr = ovr_evt ? 1 : 0;
                m_frm = Error2 ? 1 : 0;
            end else begin
                if (ovr_evt && m_ovr < CMAX) m_ovr++;
                if (Error2 && m_frm < CMAX)  m_frm++;
            end
            if (ovr_evt || Error2) m_err = 1;
            else if (clr_err)      m_err = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes rd_valid.
    always @(negedge clk) begin
        if (rst_b) begin
            chk("rd_valid", rd_valid, m_valid);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("read_not_ready_in", read_not_ready_in, mq.size() == DEPTH);
            chk("overrun_cnt", overrun_cnt, m_ovr);
            chk("framing_cnt", framing_cnt, m_frm);
            chk("err_sticky", err_sticky, m_err);
        end
    end

    // Receiver emulation: the data register changes in the cycle after the pulse.
    bit            load_nxt = 0;
    logic [WS-1:0] nxt_w    = '0;

    task automatic step(input bit p, input bit e1, input bit e2,
                        input logic [WS-1:0] w, input bit rd, input bit clr);
        @(negedge clk);
        if (load_nxt) RCV_datareg = nxt_w;
        load_nxt           = p;
        nxt_w              = w;
        read_not_ready_out = p;
        Error1             = e1;
        Error2             = e2;
        rd_req             = rd;
        clr_err            = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit last_p;
        rst_b = 0; RCV_datareg = '0; read_not_ready_out = 0;
        Error1 = 0; Error2 = 0; rd_req = 0; clr_err = 0;
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_rnr_in", read_not_ready_in, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", {err_sticky, overrun_cnt, framing_cnt}, 0);
        idle(2);
        @(negedge clk) rst_b = 1;

        // Single frame then pop
        step(1, 0, 0, 8'hA5, 0, 0);
        idle(2);
        chk("single_count", count, 1);
        step(0, 0, 0, 8'h00, 1, 0);
        idle(1);
        chk("single_rd_valid", rd_valid, 1);
        chk("single_rd_data", rd_data, 8'hA5);
        chk("single_empty", empty, 1);
        idle(2);

        // Fill to full, ninth frame arrives flagged as overrun
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 0, 8'h10 + i[7:0], 0, 0);
            idle(2);
        end
        chk("fill_full", full, 1);
        chk("fill_rnr_in", read_not_ready_in, 1);
        step(1, 1, 0, 8'hEE, 0, 0);
        idle(2);
        chk("fill_overrun", overrun_cnt, 1);
        chk("fill_count", count, DEPTH);
        drain(DEPTH + 1);

        // Framing error, then clear
        step(0, 0, 0, 8'h00, 0, 1);
        step(1, 0, 1, 8'h77, 0, 0);
        idle(2);
        chk("frm_cnt", framing_cnt, 1);
        chk("frm_sticky", err_sticky, 1);
        chk("frm_nowrite", count, 0);
        step(0, 0, 0, 8'h00, 0, 1);
        idle(1);
        chk("clr_all", {err_sticky, overrun_cnt, framing_cnt}, 0);

        // Pop in the CAPTURE cycle with three words stored
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 8'h30 + i[7:0], 0, 0);
            idle(2);
        end
        step(1, 0, 0, 8'h33, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0);
        idle(1);
        chk("cap_pop_count", count, 3);
        drain(4);

        // Interleaved fill/drain across three pointer wraps
        for (int w = 0; w < 3 * DEPTH; w++) begin
            step(1, 0, 0, w[7:0], 0, 0);
            step(0, 0, 0, 8'h00, w >= 3, 0);
            step(0, 0, 0, 8'h00, 0, 0);
        end
        drain(6);
        chk("wrap_empty", empty, 1);

        // Randomized traffic, including occasional forced writes while full
        last_p = 0;
        for (int c = 0; c < 1500; c++) begin
            bit p, e1, e2;
            p  = !last_p && ($urandom_range(0, 2) == 0);
            e1 = p && ((read_not_ready_in && $urandom_range(0, 7) != 0) || $urandom_range(0, 15) == 0);
            e2 = p && ($urandom_range(0, 15) == 0);
            step(p, e1, e2, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
            last_p = p;
        end
        drain(DEPTH + 2);

        // Counter saturation and clear-versus-new-error priority
        step(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < CMAX + 5; i++) step(0, 1, 0, 8'h00, 0, 0);
        idle(1);
        chk("sat_overrun", overrun_cnt, CMAX);
        step(0, 0, 1, 8'h00, 0, 1);
        idle(1);
        chk("clr_race_frm", framing_cnt, 1);
        chk("clr_race_ovr", overrun_cnt, 0);
        chk("clr_race_sticky", err_sticky, 1);

        // Reset in the cycle after a pulse drops the pending word
        step(1, 0, 0, 8'h5A, 0, 0);
        @(posedge clk);
        #2 rst_b = 0;
        #1;
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_count", count, 0);
        load_nxt = 0;
        idle(2);
        @(negedge clk) rst_b = 1;
        idle(3);
        chk("rst_mid_nowrite", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
